// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the write-back port arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package wb_arb_pkg;

  localparam int WB_N_REQ = 4;   // requesters: mul, alu1, alu2, ld
  localparam int WB_DEPTH = 2;   // entries per requester FIFO (power of two)
  localparam int WB_DW    = 16;  // result data width
  localparam int WB_PW    = 6;   // physical register number width
  localparam int WB_RW    = 6;   // ROB index width
  localparam int WB_IW    = 2;   // requester index width

  localparam int REQ_MUL  = 0;
  localparam int REQ_ALU1 = 1;
  localparam int REQ_ALU2 = 2;
  localparam int REQ_LD   = 3;

  typedef struct packed {
    logic [WB_PW-1:0] pdst;
    logic [WB_DW-1:0] data;
    logic [WB_RW-1:0] rob;
  } wb_entry_t;

  // Requester index base+ofs, wrapping modulo the requester count.
  function automatic logic [WB_IW-1:0] wb_wrap_add(input logic [WB_IW-1:0] base,
                                                   input int unsigned ofs);
    int unsigned sum;
    sum = 32'(base) + ofs;
    return WB_IW'(sum % WB_N_REQ);
  endfunction

endpackage

// File: rtl/wb_req_fifo.sv
// Per-requester result FIFO holding completed results until a write port is granted.
// Latency: a push is visible at head the cycle after the push edge.
// Backpressure: owner must gate push with count < DEPTH; flush/rst empty it in one edge.
module wb_req_fifo
  import wb_arb_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  wb_entry_t     push_ent,
  input  logic          pop,
  output wb_entry_t     head,
  output logic [CW-1:0] count,
  output logic          empty
);

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  wb_entry_t     mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  // Storage needs no reset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_ent;
  end

  // Pointer and occupancy tracking; flush behaves like reset.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the two register-file write ports among mul/alu1/alu2/ld results, round-robin, 2 grants/cycle.
// Latency: 2 cycles push-to-write; 1 cycle for a bypassed result when WB_BYPASS_EN is defined.
// Backpressure: req_rdy[i] = FIFO i not full (registered state only); flush drops everything buffered.
module wb_port_arbiter
  import wb_arb_pkg::*;
#(
  parameter int N_REQ = WB_N_REQ,
  parameter int DEPTH = WB_DEPTH,
  parameter int DW    = WB_DW,
  parameter int PW    = WB_PW,
  parameter int RW    = WB_RW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic [N_REQ-1:0]  req_vld,
  output logic [N_REQ-1:0]  req_rdy,
  input  logic [N_REQ*PW-1:0] req_pdst,
  input  logic [N_REQ*DW-1:0] req_data,
  input  logic [N_REQ*RW-1:0] req_rob,
  output logic              wrt0_vld,
  output logic [PW-1:0]     wrt0_pnum,
  output logic [DW-1:0]     wrt0_data,
  output logic              wrt1_vld,
  output logic [PW-1:0]     wrt1_pnum,
  output logic [DW-1:0]     wrt1_data,
  output logic [RW-1:0]     done0_rob,
  output logic [RW-1:0]     done1_rob,
  output logic [1:0]        rr_ptr_o
);

  localparam int CW = $clog2(DEPTH + 1);

  wb_entry_t        in_ent   [N_REQ];
  wb_entry_t        head     [N_REQ];
  wb_entry_t        cand_ent [N_REQ];
  logic [CW-1:0]    fifo_cnt [N_REQ];
  logic [N_REQ-1:0] fifo_empty;
  logic [N_REQ-1:0] cand_vld;
  logic [N_REQ-1:0] push;
  logic [N_REQ-1:0] pop;
  logic [N_REQ-1:0] byp;

  logic [WB_IW-1:0] rr_ptr;
  logic             g0_vld, g1_vld;
  logic [WB_IW-1:0] g0_idx, g1_idx, scan_idx, rr_nxt;
  wb_entry_t        g0_ent, g1_ent;

  logic             out0_vld, out1_vld;
  wb_entry_t        out0_ent, out1_ent;

  for (genvar i = 0; i < N_REQ; i++) begin : g_req
    assign in_ent[i] = '{pdst: req_pdst[i*PW +: PW],
                         data: req_data[i*DW +: DW],
                         rob:  req_rob[i*RW +: RW]};
    assign req_rdy[i] = (fifo_cnt[i] < CW'(DEPTH));
    // A bypassed result never enters the FIFO.
    assign push[i]    = req_vld[i] & req_rdy[i] & ~byp[i];

    wb_req_fifo #(.DEPTH(DEPTH), .CW(CW)) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush),
      .push     (push[i]),
      .push_ent (in_ent[i]),
      .pop      (pop[i]),
      .head     (head[i]),
      .count    (fifo_cnt[i]),
      .empty    (fifo_empty[i])
    );
  end

  // Candidate per requester: FIFO head, or the incoming result when bypass is enabled and the FIFO is empty.
  always_comb begin
    cand_vld = '0;
    for (int i = 0; i < N_REQ; i++) begin
`ifdef WB_BYPASS_EN
      cand_vld[i] = ~fifo_empty[i] | req_vld[i];
      cand_ent[i] = fifo_empty[i] ? in_ent[i] : head[i];
`else
      cand_vld[i] = ~fifo_empty[i];
      cand_ent[i] = head[i];
`endif
    end
  end

  // Round-robin scan from rr_ptr: first candidate to port 0, next one to port 1.
  always_comb begin
    g0_vld   = 1'b0;
    g1_vld   = 1'b0;
    g0_idx   = '0;
    g1_idx   = '0;
    scan_idx = '0;
    for (int k = 0; k < N_REQ; k++) begin
      scan_idx = wb_wrap_add(rr_ptr, k);
      if (cand_vld[scan_idx]) begin
        if (!g0_vld) begin
          g0_vld = 1'b1;
          g0_idx = scan_idx;
        end else if (!g1_vld) begin
          g1_vld = 1'b1;
          g1_idx = scan_idx;
        end
      end
    end
    g0_ent = cand_ent[g0_idx];
    g1_ent = cand_ent[g1_idx];
    rr_nxt = wb_wrap_add(g1_vld ? g1_idx : g0_idx, 1);
  end

  // Each grant consumes exactly one result: pop a stored head, or mark the incoming one as bypassed.
  always_comb begin
    pop = '0;
    byp = '0;
    if (g0_vld) begin
      if (fifo_empty[g0_idx]) byp[g0_idx] = 1'b1;
      else                    pop[g0_idx] = 1'b1;
    end
    if (g1_vld) begin
      if (fifo_empty[g1_idx]) byp[g1_idx] = 1'b1;
      else                    pop[g1_idx] = 1'b1;
    end
  end

  // Registered write ports and round-robin pointer; flush kills outputs but keeps rr_ptr.
  always_ff @(posedge clk) begin
    if (rst) begin
      out0_vld <= 1'b0;
      out1_vld <= 1'b0;
      out0_ent <= '0;
      out1_ent <= '0;
      rr_ptr   <= '0;
    end else if (flush) begin
      out0_vld <= 1'b0;
      out1_vld <= 1'b0;
      out0_ent <= '0;
      out1_ent <= '0;
    end else begin
      out0_vld <= g0_vld;
      out1_vld <= g1_vld;
      out0_ent <= g0_vld ? g0_ent : '0;
      out1_ent <= g1_vld ? g1_ent : '0;
      if (g0_vld) rr_ptr <= rr_nxt;
    end
  end

  assign wrt0_vld  = out0_vld;
  assign wrt0_pnum = out0_ent.pdst;
  assign wrt0_data = out0_ent.data;
  assign done0_rob = out0_ent.rob;
  assign wrt1_vld  = out1_vld;
  assign wrt1_pnum = out1_ent.pdst;
  assign wrt1_data = out1_ent.data;
  assign done1_rob = out1_ent.rob;
  assign rr_ptr_o  = rr_ptr;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: queue-based reference model plus directed scenarios.
// Latency: checks outputs on the falling edge after each active edge.
// Backpressure: drivers only raise req_vld when the model FIFO has room.
module tb_wb_port_arbiter;
  import wb_arb_pkg::*;

`ifdef WB_BYPASS_EN
  localparam bit BYP = 1'b1;
  localparam int LAT = 1;
`else
  localparam bit BYP = 1'b0;
  localparam int LAT = 2;
`endif

  logic                      clk, rst, flush;
  logic [WB_N_REQ-1:0]       req_vld, req_rdy;
  logic [WB_N_REQ*WB_PW-1:0] req_pdst;
  logic [WB_N_REQ*WB_DW-1:0] req_data;
  logic [WB_N_REQ*WB_RW-1:0] req_rob;
  logic                      wrt0_vld, wrt1_vld;
  logic [WB_PW-1:0]          wrt0_pnum, wrt1_pnum;
  logic [WB_DW-1:0]          wrt0_data, wrt1_data;
  logic [WB_RW-1:0]          done0_rob, done1_rob;
  logic [1:0]                rr_ptr_o;

  wb_port_arbiter dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req_vld(req_vld), .req_rdy(req_rdy),
    .req_pdst(req_pdst), .req_data(req_data), .req_rob(req_rob),
    .wrt0_vld(wrt0_vld), .wrt0_pnum(wrt0_pnum), .wrt0_data(wrt0_data),
    .wrt1_vld(wrt1_vld), .wrt1_pnum(wrt1_pnum), .wrt1_data(wrt1_data),
    .done0_rob(done0_rob), .done1_rob(done1_rob),
    .rr_ptr_o(rr_ptr_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  wb_entry_t mq [WB_N_REQ][$];
  wb_entry_t exp_q [$];
  int        cand [$];
  bit        m_v0, m_v1;
  logic [1:0] m_rr;
  bit        m_byp [WB_N_REQ];
  bit        m_room [WB_N_REQ];
  int        m_last, m_g;
  wb_entry_t m_e;

  bit        mon_en = 0;
  bit        obs_en = 0;
  bit        cnt_en = 0;
  bit        seen_3f = 0;
  logic [WB_PW-1:0] obs_q [$];
  int        grants [WB_N_REQ];
  int        last_g [WB_N_REQ];
  int        win_cyc, max_gap, seq;

  function automatic wb_entry_t incoming(input int i);
    return '{pdst: req_pdst[i*WB_PW +: WB_PW], data: req_data[i*WB_DW +: WB_DW],
             rob: req_rob[i*WB_RW +: WB_RW]};
  endfunction

  // Model: per-requester queues, candidate list ordered from rr pointer, first two win.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < WB_N_REQ; i++) mq[i].delete();
      m_v0 = 0; m_v1 = 0; m_rr = 2'd0; exp_q.delete();
    end else begin
      vectors++;
      if ((req_vld & ~req_rdy) != '0) begin
        miscompares++;
        $display("FAIL protocol: req_vld=%b while req_rdy=%b", req_vld, req_rdy);
      end
      if (flush) begin
        for (int i = 0; i < WB_N_REQ; i++) mq[i].delete();
        m_v0 = 0; m_v1 = 0;
      end else begin
        cand.delete();
        for (int i = 0; i < WB_N_REQ; i++) begin
          m_byp[i]  = 0;
          m_room[i] = (mq[i].size() < WB_DEPTH);
        end
        for (int k = 0; k < WB_N_REQ; k++) begin
          m_g = (int'(m_rr) + k) % WB_N_REQ;
          if (mq[m_g].size() != 0 || (BYP && req_vld[m_g])) cand.push_back(m_g);
        end
        m_v0 = 0; m_v1 = 0; m_last = -1;
        for (int p = 0; p < 2; p++) begin
          if (cand.size() > p) begin
            m_g = cand[p];
            if (mq[m_g].size() != 0) m_e = mq[m_g].pop_front();
            else begin m_e = incoming(m_g); m_byp[m_g] = 1; end
            exp_q.push_back(m_e);
            if (p == 0) m_v0 = 1; else m_v1 = 1;
            m_last = m_g;
          end
        end
        if (m_last >= 0) m_rr = 2'((m_last + 1) % WB_N_REQ);
        for (int i = 0; i < WB_N_REQ; i++)
          if (req_vld[i] && m_room[i] && !m_byp[i]) mq[i].push_back(incoming(i));
      end
    end
  end

  // Monitor: compare DUT against the model away from the active edge.
  always @(negedge clk) begin
    if (mon_en) begin
      vectors++;
      if (wrt0_vld !== m_v0) begin miscompares++; $display("FAIL wrt0_vld: got %b want %b", wrt0_vld, m_v0); end
      vectors++;
      if (wrt1_vld !== m_v1) begin miscompares++; $display("FAIL wrt1_vld: got %b want %b", wrt1_vld, m_v1); end
      vectors++;
      if (rr_ptr_o !== m_rr) begin miscompares++; $display("FAIL rr_ptr: got %0d want %0d", rr_ptr_o, m_rr); end
      for (int i = 0; i < WB_N_REQ; i++) begin
        vectors++;
        if (req_rdy[i] !== (mq[i].size() < WB_DEPTH)) begin
          miscompares++; $display("FAIL req_rdy[%0d]: got %b want %b", i, req_rdy[i], mq[i].size() < WB_DEPTH);
        end
      end
      vectors++;
      if (wrt0_vld === 1'b1) begin
        if (exp_q.size() == 0) begin miscompares++; $display("FAIL wrt0 unexpected write pnum=%0d", wrt0_pnum); end
        else begin
          m_e = exp_q.pop_front();
          if ({wrt0_pnum, wrt0_data, done0_rob} !== m_e) begin
            miscompares++; $display("FAIL wrt0 payload: got %h want %h", {wrt0_pnum, wrt0_data, done0_rob}, m_e);
          end
        end
      end else if ({wrt0_pnum, wrt0_data, done0_rob} !== '0) begin
        miscompares++; $display("FAIL wrt0 idle payload: got %h want 0", {wrt0_pnum, wrt0_data, done0_rob});
      end
      vectors++;
      if (wrt1_vld === 1'b1) begin
        if (exp_q.size() == 0) begin miscompares++; $display("FAIL wrt1 unexpected write pnum=%0d", wrt1_pnum); end
        else begin
          m_e = exp_q.pop_front();
          if ({wrt1_pnum, wrt1_data, done1_rob} !== m_e) begin
            miscompares++; $display("FAIL wrt1 payload: got %h want %h", {wrt1_pnum, wrt1_data, done1_rob}, m_e);
          end
        end
      end else if ({wrt1_pnum, wrt1_data, done1_rob} !== '0) begin
        miscompares++; $display("FAIL wrt1 idle payload: got %h want 0", {wrt1_pnum, wrt1_data, done1_rob});
      end
      vectors++;
      if (exp_q.size() != 0) begin
        miscompares++; $display("FAIL missing write: %0d expected results not seen", exp_q.size());
        exp_q.delete();
      end
      if (wrt0_vld === 1'b1 && wrt0_pnum == 6'h3F) seen_3f = 1;
      if (wrt1_vld === 1'b1 && wrt1_pnum == 6'h3F) seen_3f = 1;
      if (obs_en) begin
        if (wrt0_vld === 1'b1) obs_q.push_back(wrt0_pnum);
        if (wrt1_vld === 1'b1) obs_q.push_back(wrt1_pnum);
      end
      if (cnt_en) begin
        win_cyc++;
        if (wrt0_vld === 1'b1) begin
          m_g = int'(wrt0_pnum[5:4]); grants[m_g]++;
          if (last_g[m_g] >= 0 && win_cyc - last_g[m_g] > max_gap) max_gap = win_cyc - last_g[m_g];
          last_g[m_g] = win_cyc;
        end
        if (wrt1_vld === 1'b1) begin
          m_g = int'(wrt1_pnum[5:4]); grants[m_g]++;
          if (last_g[m_g] >= 0 && win_cyc - last_g[m_g] > max_gap) max_gap = win_cyc - last_g[m_g];
          last_g[m_g] = win_cyc;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    req_vld = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  // One push attempt this cycle; a full FIFO means the requester holds (no vld).
  task automatic set_req(input int i, input logic [WB_PW-1:0] p, input logic [WB_DW-1:0] d,
                         input logic [WB_RW-1:0] r);
    req_vld[i] = (mq[i].size() < WB_DEPTH);
    req_pdst[i*WB_PW +: WB_PW] = p;
    req_data[i*WB_DW +: WB_DW] = d;
    req_rob[i*WB_RW +: WB_RW]  = r;
  endtask

  task automatic push_all();
    for (int i = 0; i < WB_N_REQ; i++) begin
      set_req(i, 6'((i << 4) | (seq & 15)), 16'(16'hB000 + seq), 6'(seq));
      seq++;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    vectors++;
    if ({wrt0_vld, wrt1_vld, wrt0_pnum, wrt1_pnum, wrt0_data, wrt1_data, done0_rob, done1_rob} !== '0) begin
      miscompares++; $display("FAIL reset outputs: got nonzero (wrt0_vld=%b wrt1_vld=%b) want all 0", wrt0_vld, wrt1_vld);
    end
    vectors++;
    if (rr_ptr_o !== 2'd0) begin miscompares++; $display("FAIL reset rr_ptr: got %0d want 0", rr_ptr_o); end
    vectors++;
    if (req_rdy !== 4'hF) begin miscompares++; $display("FAIL reset req_rdy: got %b want 1111", req_rdy); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_single();
    set_req(REQ_ALU1, 6'd5, 16'h1234, 6'd3);
    step();
    if (LAT == 2) step();
    @(negedge clk);
    vectors++;
    if ({wrt0_vld, wrt0_pnum, wrt0_data, done0_rob} !== {1'b1, 6'd5, 16'h1234, 6'd3}) begin
      miscompares++;
      $display("FAIL single write: got vld=%b pnum=%0d data=%h rob=%0d want 1/5/1234/3", wrt0_vld, wrt0_pnum, wrt0_data, done0_rob);
    end
    vectors++;
    if (wrt1_vld !== 1'b0) begin miscompares++; $display("FAIL single wrt1_vld: got %b want 0", wrt1_vld); end
    vectors++;
    if (rr_ptr_o !== 2'd2) begin miscompares++; $display("FAIL single rr_ptr: got %0d want 2", rr_ptr_o); end
    idle(3);
  endtask

  task automatic test_all_four();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < WB_N_REQ; i++) set_req(i, 6'(16 + i), 16'(16'hC000 + i), 6'(40 + i));
    step();
    if (LAT == 2) step();
    @(negedge clk);
    vectors++;
    if ({wrt0_vld, wrt0_pnum, wrt1_vld, wrt1_pnum, rr_ptr_o} !== {1'b1, 6'd16, 1'b1, 6'd17, 2'd2}) begin
      miscompares++; $display("FAIL all_four first: got p0=%0d p1=%0d rr=%0d want 16/17/2", wrt0_pnum, wrt1_pnum, rr_ptr_o);
    end
    step();
    @(negedge clk);
    vectors++;
    if ({wrt0_vld, wrt0_pnum, wrt1_vld, wrt1_pnum, rr_ptr_o} !== {1'b1, 6'd18, 1'b1, 6'd19, 2'd0}) begin
      miscompares++; $display("FAIL all_four second: got p0=%0d p1=%0d rr=%0d want 18/19/0", wrt0_pnum, wrt1_pnum, rr_ptr_o);
    end
    idle(3);
  endtask

  task automatic test_back_to_back();
    obs_q.delete();
    obs_en = 1;
    for (int k = 0; k < 3; k++) begin
      set_req(REQ_MUL, 6'(10 + k), 16'(16'hD000 + k), 6'(k));
      step();
    end
    idle(4);
    obs_en = 0;
    vectors++;
    if (obs_q.size() != 3) begin
      miscompares++; $display("FAIL back_to_back count: got %0d writes want 3", obs_q.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        vectors++;
        if (obs_q[k] !== 6'(10 + k)) begin
          miscompares++; $display("FAIL back_to_back order[%0d]: got %0d want %0d", k, obs_q[k], 10 + k);
        end
      end
    end
  endtask

  task automatic test_flush();
    logic [1:0] rr_save;
    seen_3f = 0;
    for (int i = 0; i < 3; i++) set_req(i, 6'(32 + i), 16'(16'hE000 + i), 6'(i));
    step();
    rr_save = m_rr;
    set_req(REQ_LD, 6'h3F, 16'hDEAD, 6'd9);
    flush = 1'b1;
    step();
    flush = 1'b0;
    @(negedge clk);
    vectors++;
    if ({wrt0_vld, wrt1_vld} !== 2'b00) begin
      miscompares++; $display("FAIL flush vld: got %b%b want 00", wrt0_vld, wrt1_vld);
    end
    vectors++;
    if (req_rdy !== 4'hF) begin miscompares++; $display("FAIL flush req_rdy: got %b want 1111", req_rdy); end
    vectors++;
    if (rr_ptr_o !== rr_save) begin miscompares++; $display("FAIL flush rr_ptr: got %0d want %0d", rr_ptr_o, rr_save); end
    idle(4);
    vectors++;
    if (seen_3f) begin miscompares++; $display("FAIL flush dropped pdst written: got 3f written want never"); end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < WB_N_REQ; i++) begin grants[i] = 0; last_g[i] = -1; end
    win_cyc = 0; max_gap = 0;
    for (int k = 0; k < LAT + 20; k++) begin
      push_all();
      step();
      cnt_en = (k + 1 >= LAT) && (k + 1 < LAT + 20);
    end
    @(negedge clk);
    cnt_en = 0;
    for (int i = 0; i < WB_N_REQ; i++) begin
      vectors++;
      if (grants[i] != 10) begin
        miscompares++; $display("FAIL saturation grants[%0d]: got %0d want 10", i, grants[i]);
      end
    end
    vectors++;
    if (max_gap > 2) begin miscompares++; $display("FAIL saturation gap: got %0d want <=2", max_gap); end
  endtask

  task automatic test_reset_mid();
    repeat (3) begin push_all(); step(); end
    @(negedge clk);
    vectors++;
    if (wrt0_vld !== 1'b1) begin miscompares++; $display("FAIL reset_mid precondition wrt0_vld: got %b want 1", wrt0_vld); end
    push_all();
    rst = 1'b1;
    flush = 1'b1;
    step();
    rst = 1'b0;
    flush = 1'b0;
    @(negedge clk);
    vectors++;
    if ({wrt0_vld, wrt1_vld, wrt0_pnum, wrt1_pnum, wrt0_data, wrt1_data, done0_rob, done1_rob} !== '0) begin
      miscompares++; $display("FAIL reset_mid outputs: got vld=%b%b want all 0", wrt0_vld, wrt1_vld);
    end
    vectors++;
    if (rr_ptr_o !== 2'd0) begin miscompares++; $display("FAIL reset_mid rr_ptr: got %0d want 0", rr_ptr_o); end
    vectors++;
    if (req_rdy !== 4'hF) begin miscompares++; $display("FAIL reset_mid req_rdy: got %b want 1111", req_rdy); end
    idle(3);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; req_vld = '0;
    req_pdst = '0; req_data = '0; req_rob = '0;
    seq = 0;
    step();
    mon_en = 1;
    test_reset();
    test_single();
    test_all_four();
    test_back_to_back();
    test_flush();
    test_saturation();
    test_reset_mid();
    mon_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
